clkgen_reprog: RTL
==================

# clkgen_reprog

Runtime reprogramming controller for up to NUM_CH DCM_CLKGEN frequency synthesizers in the clock tile. It serially loads new M/D values through the PROGEN/PROGDATA protocol and issues GO. It then waits for PROGDONE and LOCKED, and reports the result through a single-request handshake. Host command logic uses it to step hashing-core clocks at runtime without reconfiguring the FPGA.

## Interface
- NUM_CH, 2: number of DCM_CLKGEN instances served (1..8).
- DEFAULT_M, 35: multiplier that the readback registers hold after reset.
- DEFAULT_D, 8: divider that the readback registers hold after reset.
- DONE_TIMEOUT, 4096: maximum number of cycles to wait for PROGDONE after GO.
- LOCK_TIMEOUT, 65536: maximum number of cycles to wait for LOCKED after PROGDONE.
- CLK  in  1  program clock; also drives the PROGCLK pins of all DCM_CLKGEN instances.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ch  in  3  target channel.
- req_mult  in  9  M value, legal range 2..256.
- req_div  in  9  D value, legal range 1..256.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  2  result code: 0 ok, 1 bad parameter, 2 PROGDONE timeout, 3 LOCK timeout.
- progen  out  NUM_CH  per-channel PROGEN.
- progdata  out  1  PROGDATA, shared by all channels.
- progdone  in  NUM_CH  per-channel PROGDONE.
- locked  in  NUM_CH  per-channel LOCKED.
- cur_mult  out  9*NUM_CH  last successfully programmed M per channel (channel 0 in the low bits).
- cur_div  out  9*NUM_CH  last successfully programmed D per channel (channel 0 in the low bits).

## Operation
- Reset values:
  - state IDLE, req_ready=1.
  - resp_valid=0, resp_err=0.
  - progen=0, progdata=0.
  - all cur_mult=DEFAULT_M, all cur_div=DEFAULT_D.
  - counters cleared.
- Acceptance: a request is accepted on the cycle where req_valid and req_ready are both high. req_ch, req_mult and req_div are latched on that cycle.
- Validation: the request is rejected with code 1 if req_ch>=NUM_CH, req_mult<2, req_mult>256, req_div<1 or req_div>256.
  - The controller goes to RESP. No progen activity occurs and cur_* is unchanged.
- States: IDLE -> LOAD_D -> GAP_D -> LOAD_M -> GAP_M -> GO -> WAIT_DONE -> WAIT_LOCK -> RESP -> IDLE.
- LOAD_D, 10 cycles:
  - progen[ch]=1 throughout.
  - progdata sends command bits 1,0, then D-1 as 8 bits, LSB first.
- GAP_D, 1 cycle: progen=0, progdata=0.
- LOAD_M, 10 cycles:
  - progen[ch]=1 throughout.
  - progdata sends command bits 1,1, then M-1 as 8 bits, LSB first.
- GAP_M, 1 cycle: progen=0.
- GO, 1 cycle: progen[ch]=1, progdata=0.
- WAIT_DONE:
  - Waits for the synchronised progdone[ch]=1.
  - If the counter reaches DONE_TIMEOUT first, the result is code 2.
- WAIT_LOCK:
  - Waits for the synchronised locked[ch]=1.
  - If the counter reaches LOCK_TIMEOUT first, the result is code 3.
- RESP, 1 cycle:
  - resp_valid=1 and resp_err is valid.
  - On code 0 only, cur_mult/cur_div[ch] update on this cycle.
- Unselected channels: progen bits for channels other than the target are 0 at all times.
- Input synchronisation: progdone and locked each pass through a 2-flop synchroniser before any use.
- Reset mid-sequence: the controller aborts immediately to IDLE with all outputs at reset values. No response is emitted for the aborted request.

## Timing
- Cycle numbering: cycle 0 is the accept edge.
  - LOAD_D occupies cycles 1..10.
  - GAP_D is cycle 11.
  - LOAD_M occupies cycles 12..21.
  - GAP_M is cycle 22.
  - GO is cycle 23.
  - WAIT_DONE starts at cycle 24.
- Minimum latency to resp_valid:
  - progdone and locked already high (synchronised) at cycle 24: resp_valid at cycle 26.
  - Bad-parameter request: resp_valid at cycle 1.
- Timeout counters are cleared on entry to each wait state. The timeout fires on the cycle the count equals the limit.
- Simultaneous events: if progdone rises on the same cycle as the timeout, success wins. The same rule applies to locked.
- req_ready=0 from cycle 1 until the cycle after RESP. The earliest next accept is therefore 1 cycle after resp_valid.
- Back-to-back requests to the same channel are allowed. No minimum spacing is required beyond the handshake.

## Test plan
- Reset, then read back: every cur_mult=35, every cur_div=8, req_ready=1, progen=0.
- Request ch1, M=40, D=8, with a progdone/locked model that responds after 5 cycles:
  - progen[1] is high on cycles 1-10 and 12-21, and for one cycle at 23.
  - progdata shows 1,0 then 7 LSB-first on cycles 1-10, and 1,1 then 39 LSB-first on cycles 12-21.
  - resp_err=0.
  - cur_mult[ch1]=40 and cur_div[ch1]=8.
- Bad-parameter cases, one request each: M=1, then D=0, then M=257, then ch=NUM_CH.
  - Each gives resp_valid at cycle 1 with resp_err=1.
  - progen stays at 0 and cur_* is unchanged.
- Hold progdone low, with DONE_TIMEOUT set to 16 in the bench: resp_err=2 and cur_* is unchanged.
- progdone high but locked held low: resp_err=3.
- Assert RESET at cycle 15 of a sequence: the controller returns to IDLE, no resp_valid appears, and a fresh request then completes with code 0.

Source files
------------

// File: rtl/clkgen_reprog.sv
// Runtime M/D reprogramming controller for DCM_CLKGEN instances: serial PROGEN/PROGDATA
// load, GO, then wait for PROGDONE and LOCKED with timeouts, reported through a request/response handshake.
module clkgen_reprog #(
    parameter int NUM_CH       = 2,
    parameter int DEFAULT_M    = 35,
    parameter int DEFAULT_D    = 8,
    parameter int DONE_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                  CLK,
    input  logic                  RESET,
    // Handshake: a request is taken on any edge where req_valid && req_ready; req_ready is high
    // only while idle, and each accepted request yields exactly one resp_valid pulse.
    input  logic                  req_valid,
    input  logic [2:0]            req_ch,
    input  logic [8:0]            req_mult,
    input  logic [8:0]            req_div,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [1:0]            resp_err,
    output logic [NUM_CH-1:0]     progen,
    output logic                  progdata,
    input  logic [NUM_CH-1:0]     progdone,
    input  logic [NUM_CH-1:0]     locked,
    output logic [9*NUM_CH-1:0]   cur_mult,
    output logic [9*NUM_CH-1:0]   cur_div,
    output logic [3:0]            dbg_state
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_D,
        ST_GAP_D,
        ST_LOAD_M,
        ST_GAP_M,
        ST_GO,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_RESP
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_PARAM = 2'd1;
    localparam logic [1:0] ERR_DONE  = 2'd2;
    localparam logic [1:0] ERR_LOCK  = 2'd3;

    localparam int CNT_MAX = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(DONE_TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);

    state_t             state_q, state_d;
    logic [2:0]         ch_q;
    logic [8:0]         mult_q, div_q;
    logic [1:0]         err_q;
    logic [3:0]         bit_cnt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_CH-1:0]  done_s1, done_s2, lock_s1, lock_s2;
    logic [8:0]         cur_m [NUM_CH];
    logic [8:0]         cur_d [NUM_CH];

    logic [NUM_CH-1:0]  ch_sel;
    logic               bad_req, bit_last, done_hit, lock_hit, done_tmo, lock_tmo;
    logic [7:0]         d_val, m_val;
    logic [9:0]         frame_d, frame_m;

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (ch_q == 3'(i));
        end
    end

    assign bad_req  = (32'(req_ch) >= NUM_CH) || (req_mult < 9'd2) || (req_mult > 9'd256)
                   || (req_div == 9'd0) || (req_div > 9'd256);
    assign bit_last = (bit_cnt == 4'd9);
    assign done_hit = |(done_s2 & ch_sel);
    assign lock_hit = |(lock_s2 & ch_sel);
    assign done_tmo = (wait_cnt == DONE_LIM);
    assign lock_tmo = (wait_cnt == LOCK_LIM);

    // Frames go out LSB first: start bit 1, opcode bit (0 = D, 1 = M), then the value minus one.
    assign d_val   = 8'(div_q - 9'd1);
    assign m_val   = 8'(mult_q - 9'd1);
    assign frame_d = {d_val, 2'b01};
    assign frame_m = {m_val, 2'b11};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = ERR_OK;
        progen     = '0;
        progdata   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = bad_req ? ST_RESP : ST_LOAD_D;
            end
            ST_LOAD_D: begin
                progen   = ch_sel;
                progdata = frame_d[bit_cnt];
                if (bit_last) state_d = ST_GAP_D;
            end
            ST_GAP_D: state_d = ST_LOAD_M;
            ST_LOAD_M: begin
                progen   = ch_sel;
                progdata = frame_m[bit_cnt];
                if (bit_last) state_d = ST_GAP_M;
            end
            ST_GAP_M: state_d = ST_GO;
            ST_GO: begin
                progen  = ch_sel;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A PROGDONE arriving on the timeout cycle still counts as success.
                if (done_hit)      state_d = ST_WAIT_LOCK;
                else if (done_tmo) state_d = ST_RESP;
            end
            ST_WAIT_LOCK: begin
                if (lock_hit || lock_tmo) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ch_q     <= '0;
            mult_q   <= '0;
            div_q    <= '0;
            err_q    <= ERR_OK;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            done_s1  <= '0;
            done_s2  <= '0;
            lock_s1  <= '0;
            lock_s2  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_m[i] <= 9'(DEFAULT_M);
                cur_d[i] <= 9'(DEFAULT_D);
            end
        end else begin
            done_s1 <= progdone;
            done_s2 <= done_s1;
            lock_s1 <= locked;
            lock_s2 <= lock_s1;

            if ((state_q == ST_LOAD_D || state_q == ST_LOAD_M) && !bit_last) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= '0;
            end

            // Counts only while staying in a wait state, so it restarts at zero on each entry.
            if ((state_q == ST_WAIT_DONE || state_q == ST_WAIT_LOCK) && state_d == state_q) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        ch_q   <= req_ch;
                        mult_q <= req_mult;
                        div_q  <= req_div;
                        err_q  <= bad_req ? ERR_PARAM : ERR_OK;
                    end
                end
                ST_WAIT_DONE: if (!done_hit && done_tmo) err_q <= ERR_DONE;
                ST_WAIT_LOCK: if (!lock_hit && lock_tmo) err_q <= ERR_LOCK;
                ST_RESP: begin
                    if (err_q == ERR_OK) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_sel[i]) begin
                                cur_m[i] <= mult_q;
                                cur_d[i] <= div_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cur
        assign cur_mult[g*9 +: 9] = cur_m[g];
        assign cur_div[g*9 +: 9]  = cur_d[g];
    end

    assign dbg_state = state_q;

endmodule
